// File: rtl/ula_issue_ctrl_pkg.sv
// ula_issue_ctrl_pkg
//   Shared definitions for the ULA issue/writeback controller:
//   default datapath widths, FSM state encoding and ULA op code constants.
//   The controller treats op codes as opaque; the constants document the
//   codes used by the REDUX-V ULA.
package ula_issue_ctrl_pkg;

  localparam int DEF_BITS     = 8;  // datapath width
  localparam int DEF_ULA_OP   = 4;  // ULA op code width
  localparam int DEF_REG_ADDR = 2;  // register-file address width

  // Controller FSM, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // ULA op codes (opaque to the controller)
  localparam logic [DEF_ULA_OP-1:0] ULA_NOT = 4'd0;
  localparam logic [DEF_ULA_OP-1:0] ULA_ADD = 4'd1;
  localparam logic [DEF_ULA_OP-1:0] ULA_SUB = 4'd2;
  localparam logic [DEF_ULA_OP-1:0] ULA_AND = 4'd3;
  localparam logic [DEF_ULA_OP-1:0] ULA_OR  = 4'd4;
  localparam logic [DEF_ULA_OP-1:0] ULA_XOR = 4'd5;

endpackage

// File: rtl/ula_issue_ctrl.sv
// ula_issue_ctrl
//   Multi-cycle issue/writeback controller for one register-register ALU
//   request at a time: ra <- ra op rb.
//   Sequence: IDLE (accept) -> READ (register file) -> EXEC (ULA) -> WB.
//
// Handshake: a request transfers on a rising clk_in edge where both
//   req_valid_in and req_ready_out are 1. req_ready_out is 1 only in IDLE and
//   never while rst_in is high; request fields are sampled only at that edge.
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   req_valid_in/ready_out    request handshake
//   req_op_in/ra_in/rb_in     op code, operand A/destination, operand B
//   rf_ra_addr_out/rb_addr    register-file read addresses
//   rf_ra_data_in/rb_data_in  register-file read data (combinational)
//   ula_a_out/b_out/op_out    ULA operands and op code
//   ula_result_in             ULA result
//   rf_we_out/wr_addr/wr_data register-file write port
//   done_out                  one-cycle pulse in the writeback cycle
//   zero_out                  last written result was zero (sticky)
//   state_dbg_out             current FSM state (debug)
module ula_issue_ctrl
  import ula_issue_ctrl_pkg::*;
#(
  parameter int BITS     = DEF_BITS,
  parameter int ULA_OP   = DEF_ULA_OP,
  parameter int REG_ADDR = DEF_REG_ADDR
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                req_valid_in,
  output logic                req_ready_out,
  input  logic [ULA_OP-1:0]   req_op_in,
  input  logic [REG_ADDR-1:0] req_ra_in,
  input  logic [REG_ADDR-1:0] req_rb_in,
  output logic [REG_ADDR-1:0] rf_ra_addr_out,
  output logic [REG_ADDR-1:0] rf_rb_addr_out,
  input  logic [BITS-1:0]     rf_ra_data_in,
  input  logic [BITS-1:0]     rf_rb_data_in,
  output logic [BITS-1:0]     ula_a_out,
  output logic [BITS-1:0]     ula_b_out,
  output logic [ULA_OP-1:0]   ula_op_out,
  input  logic [BITS-1:0]     ula_result_in,
  output logic                rf_we_out,
  output logic [REG_ADDR-1:0] rf_wr_addr_out,
  output logic [BITS-1:0]     rf_wr_data_out,
  output logic                done_out,
  output logic                zero_out,
  output logic [1:0]          state_dbg_out
);

  state_e              state_q, state_d;
  logic [ULA_OP-1:0]   op_q,    op_d;
  logic [REG_ADDR-1:0] ra_q,    ra_d;
  logic [REG_ADDR-1:0] rb_q,    rb_d;
  logic [BITS-1:0]     a_q,     a_d;
  logic [BITS-1:0]     b_q,     b_d;
  logic [BITS-1:0]     res_q,   res_d;
  logic                zero_q,  zero_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_in) begin
          op_d    = req_op_in;
          ra_d    = req_ra_in;
          rb_d    = req_rb_in;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        a_d     = rf_ra_data_in;
        b_d     = rf_rb_data_in;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_d   = ula_result_in;
        state_d = ST_WB;
      end
      ST_WB: begin
        zero_d  = (res_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  // Address/data outputs always reflect the holding registers; they only
  // matter in the state that owns them and read 0 after reset.
  assign rf_ra_addr_out = ra_q;
  assign rf_rb_addr_out = rb_q;
  assign ula_a_out      = a_q;
  assign ula_b_out      = b_q;
  assign ula_op_out     = op_q;
  assign rf_wr_addr_out = ra_q;
  assign rf_wr_data_out = res_q;

  // Gated by rst_in so a reset arriving during WB suppresses the write at
  // that same edge, and no request is offered while reset is held.
  assign rf_we_out      = (state_q == ST_WB) && !rst_in;
  assign done_out       = (state_q == ST_WB) && !rst_in;
  assign req_ready_out  = (state_q == ST_IDLE) && !rst_in;
  assign zero_out       = zero_q;
  assign state_dbg_out  = state_q;

endmodule
